resetpoly_ctrl: RTL

RESETPOLY_CTRL -- requirements
Module: resetpoly_ctrl

---
 rtl/resetpoly_ctrl_pkg.sv | 57 +++++
 rtl/resetpoly_ctrl_rr_arb2.sv | 47 ++++
 rtl/resetpoly_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/resetpoly_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// resetpoly_ctrl_pkg
// Shared definitions for the polynomial clear controller:
//   - default coefficient count and index width
//   - FSM state enumeration
//   - grant vector type
//   - datapath control vector (R1/R4/R6/R7/R9) and its per-state encodings
// ---------------------------------------------------------------------------
package resetpoly_ctrl_pkg;

  localparam int N_COEF_DEF = 757;
  localparam int AW_DEF     = 11;
  localparam int N_COEF_MAX = 2048;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One-hot grant, bit n serves req[n]; all-zero means nobody is served.
  typedef logic [1:0] grant_t;

  // Datapath control vector:
  //   r7/r1 : index   (r7 holds, else r1 ? i+1 : 0)
  //   r9/r4 : address (r9 holds, else r4 ? i   : 0)
  //   r6    : write enable for the next cycle
  typedef struct packed {
    logic r1;
    logic r4;
    logic r6;
    logic r7;
    logic r9;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE  = '{r1: 1'b0, r4: 1'b0, r6: 1'b0, r7: 1'b0, r9: 1'b0};
  // Count i up, copy i into addr one cycle later, write every cycle.
  localparam ctrl_t CTRL_CLEAR = '{r1: 1'b1, r4: 1'b1, r6: 1'b1, r7: 1'b0, r9: 1'b0};
  // Freeze i and addr so the last write (addr N_COEF-1) lands, then stop writing.
  localparam ctrl_t CTRL_FLUSH = '{r1: 1'b0, r4: 1'b0, r6: 1'b0, r7: 1'b1, r9: 1'b1};
  // Zeroing here returns the datapath to i=0, addr=0 on the way back to idle.
  localparam ctrl_t CTRL_DONE  = '{r1: 1'b0, r4: 1'b0, r6: 1'b0, r7: 1'b0, r9: 1'b0};

  function automatic ctrl_t ctrl_for(input state_e st);
    ctrl_t c;
    case (st)
      ST_IDLE:  c = CTRL_IDLE;
      ST_CLEAR: c = CTRL_CLEAR;
      ST_FLUSH: c = CTRL_FLUSH;
      ST_DONE:  c = CTRL_DONE;
      default:  c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/resetpoly_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   req   : request bits, one per requester
//   en    : accept the current grant (updates the last-served pointer)
//   gnt   : combinational one-hot grant for the current requests
// With both requests high the requester not served last wins; a lone
// request always wins. After reset req[1] counts as last served, so req[0]
// wins the first contested arbitration.
// ---------------------------------------------------------------------------
module rr_arb2
  import resetpoly_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1 means req[1] was served last.
  logic   last_q;
  grant_t gnt_c;

  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (en && (gnt_c != 2'b00)) begin
      last_q <= gnt_c[1];
    end
  end

  assign gnt = gnt_c;

endmodule

// File: rtl/resetpoly_ctrl.sv
// ---------------------------------------------------------------------------
// resetpoly_ctrl
// Controller that clears N_COEF polynomial coefficients for one of two
// owners. The external datapath holds index i and address addr and obeys
// the R* controls; this block only sequences it.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req[1:0] : level clear requests, held until done
//   i_fb     : current datapath index
//   R1,R4,R6,R7,R9 : datapath controls (see resetpoly_ctrl_pkg::ctrl_t)
//   gnt[1:0] : one-hot grant of the owner being cleared, 0 when idle
//   bank_sel : memory bank of the served owner (0 = req[0], 1 = req[1])
//   busy     : high outside IDLE
//   done     : one-cycle completion pulse
// Sequence: IDLE -> CLEAR (N_COEF cycles) -> FLUSH -> DONE -> IDLE.
// Writes trail i by one cycle, so the last address is written in FLUSH.
// ---------------------------------------------------------------------------
module resetpoly_ctrl
  import resetpoly_ctrl_pkg::*;
#(
  parameter int N_COEF = N_COEF_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [AW-1:0] i_fb,
  output logic          R1,
  output logic          R4,
  output logic          R6,
  output logic          R7,
  output logic          R9,
  output logic [1:0]    gnt,
  output logic          bank_sel,
  output logic          busy,
  output logic          done
);

  if ((N_COEF < 1) || (N_COEF > N_COEF_MAX)) begin : g_bad_ncoef
    $error("resetpoly_ctrl: N_COEF must be within 1..2048");
  end
  if ((N_COEF - 1) >= (1 << AW)) begin : g_bad_aw
    $error("resetpoly_ctrl: AW too narrow for N_COEF-1");
  end

  localparam logic [AW-1:0] LAST_IDX = AW'(N_COEF - 1);

  state_e state_q, state_d;
  grant_t gnt_q, gnt_d;
  grant_t arb_gnt;
  logic   arb_en;
  ctrl_t  ctrl;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (arb_en),
    .gnt   (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    arb_en  = 1'b0;
    ctrl    = ctrl_for(state_q);
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        // The grant is frozen here and kept until the clear finishes, so a
        // requester dropping out mid-clear has no effect on the sequence.
        if (|req) begin
          arb_en  = 1'b1;
          gnt_d   = arb_gnt;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (i_fb == LAST_IDX) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign R1       = ctrl.r1;
  assign R4       = ctrl.r4;
  assign R6       = ctrl.r6;
  assign R7       = ctrl.r7;
  assign R9       = ctrl.r9;
  assign gnt      = gnt_q;
  assign bank_sel = gnt_q[1];

endmodule
